// File: rtl/fxp_mul_pipe_if.sv
// rtl/fxp_mul_pipe_if.sv - Input/output beat handshake and packed lane data for fxp_mul_pipe
interface fxp_mul_pipe_if #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int LANES      = 4
);
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*DATA_WIDTH-1:0] a;
    logic [LANES*DATA_WIDTH-1:0] b;
    logic                        round_en;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES*OUT_WIDTH-1:0]  result;
    logic [LANES-1:0]            overflow;

    modport master (
        output in_valid, a, b, round_en, out_ready,
        input  in_ready, out_valid, result, overflow
    );

    modport slave (
        input  in_valid, a, b, round_en, out_ready,
        output in_ready, out_valid, result, overflow
    );
endinterface

// File: rtl/fxp_mul_pipe.sv
// rtl/fxp_mul_pipe.sv - Multi-lane pipelined signed fixed-point multiplier with round/saturate
// Optional overflow event counter enabled by FXP_MUL_OVF_COUNT_EN.
module fxp_mul_pipe #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int OUT_WIDTH   = 16,
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    fxp_mul_pipe_if.slave bus
`ifdef FXP_MUL_OVF_COUNT_EN
    ,
    input  logic          stat_clr,
    output logic [15:0]   ovf_count
`endif
);
    localparam int PW = 2*DATA_WIDTH + 1;
    localparam int RS = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;
    localparam logic signed [PW-1:0] SAT_HI = (PW'(1) <<< (OUT_WIDTH-1)) - PW'(1);
    localparam logic signed [PW-1:0] SAT_LO = -(PW'(1) <<< (OUT_WIDTH-1));
    localparam logic signed [PW-1:0] RND_K  = PW'(1) <<< (FRAC_BITS-1);

    // One extra bit of headroom keeps the rounding add from wrapping.
    function automatic logic [OUT_WIDTH:0] mul_lane(
        input logic signed [DATA_WIDTH-1:0] x,
        input logic signed [DATA_WIDTH-1:0] y,
        input logic                         rnd
    );
        logic signed [PW-1:0] p;
        logic signed [PW-1:0] q;
        p = PW'(x) * PW'(y);
        if (rnd) p = p + RND_K;
        q = p >>> FRAC_BITS;
        if (q > SAT_HI)
            mul_lane = {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
        else if (q < SAT_LO)
            mul_lane = {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
        else
            mul_lane = {1'b0, OUT_WIDTH'(q)};
    endfunction

    logic                        advance;
    logic [LANES*DATA_WIDTH-1:0] src_a;
    logic [LANES*DATA_WIDTH-1:0] src_b;
    logic                        src_r;
    logic [LANES*OUT_WIDTH-1:0]  calc_res;
    logic [LANES-1:0]            calc_ovf;
    logic                        vld   [PIPE_STAGES];
    logic [LANES*OUT_WIDTH-1:0]  res_q [RS];
    logic [LANES-1:0]            ovf_q [RS];

    assign advance      = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = advance;

    // With two or more stages the operands get their own register so the
    // multiplier and the round/saturate logic sit in separate cycles.
    generate
        if (PIPE_STAGES > 1) begin : g_opreg
            logic [LANES*DATA_WIDTH-1:0] a_q;
            logic [LANES*DATA_WIDTH-1:0] b_q;
            logic                        r_q;
            always_ff @(posedge clk) begin
                if (advance) begin
                    a_q <= bus.a;
                    b_q <= bus.b;
                    r_q <= bus.round_en;
                end
            end
            assign src_a = a_q;
            assign src_b = b_q;
            assign src_r = r_q;
        end else begin : g_direct
            assign src_a = bus.a;
            assign src_b = bus.b;
            assign src_r = bus.round_en;
        end

        for (genvar k = 0; k < LANES; k++) begin : g_lane
            assign {calc_ovf[k], calc_res[k*OUT_WIDTH +: OUT_WIDTH]} =
                mul_lane(src_a[k*DATA_WIDTH +: DATA_WIDTH],
                         src_b[k*DATA_WIDTH +: DATA_WIDTH], src_r);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_STAGES; i++) vld[i] <= 1'b0;
            for (int i = 0; i < RS; i++) begin
                res_q[i] <= '0;
                ovf_q[i] <= '0;
            end
        end else if (advance) begin
            vld[0]   <= bus.in_valid;
            for (int i = 1; i < PIPE_STAGES; i++) vld[i] <= vld[i-1];
            res_q[0] <= calc_res;
            ovf_q[0] <= calc_ovf;
            for (int i = 1; i < RS; i++) begin
                res_q[i] <= res_q[i-1];
                ovf_q[i] <= ovf_q[i-1];
            end
        end
    end

    assign bus.out_valid = vld[PIPE_STAGES-1];
    assign bus.result    = res_q[RS-1];
    assign bus.overflow  = ovf_q[RS-1];

`ifdef FXP_MUL_OVF_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf_count <= '0;
        else if (stat_clr)
            ovf_count <= '0;
        else if (bus.out_valid && bus.out_ready && (|bus.overflow) && ovf_count != 16'hFFFF)
            ovf_count <= ovf_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fxp_mul_pipe.sv
// tb/tb_fxp_mul_pipe.sv - Self-checking bench for fxp_mul_pipe (table vectors plus randomized scoreboard)
`timescale 1ns/1ps
module tb_fxp_mul_pipe;
    localparam int DW = 16, FB = 8, OW = 16, LN = 4, PS = 2;
    localparam longint SCALE = longint'(1) << FB;
    localparam longint QMAX  = (longint'(1) << (OW-1)) - 1;
    localparam longint QMIN  = -(longint'(1) << (OW-1));

    typedef struct packed {
        logic [LN*OW-1:0] res;
        logic [LN-1:0]    ovf;
    } exp_t;

    typedef struct {
        logic [LN*DW-1:0] a;
        logic [LN*DW-1:0] b;
        logic             r;
        logic [LN*OW-1:0] res;
        logic [LN-1:0]    ovf;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fxp_mul_pipe_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .LANES(LN)) bus();

`ifdef FXP_MUL_OVF_COUNT_EN
    logic        stat_clr;
    logic [15:0] ovf_count;
`endif

    fxp_mul_pipe #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .OUT_WIDTH(OW), .LANES(LN), .PIPE_STAGES(PS)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus)
`ifdef FXP_MUL_OVF_COUNT_EN
        ,
        .stat_clr (stat_clr),
        .ovf_count(ovf_count)
`endif
    );

    int   vectors = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_ovf_cnt = 0;
    int   hs_stamp[$];
    exp_t exp_q[$];
    logic stalled_prev = 1'b0;
    logic [LN*OW-1:0] prev_res;
    logic [LN-1:0]    prev_ovf;
    vec_t tbl[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference: exact integer product, floor division by 2^FRAC, then clamp.
    function automatic exp_t model(input logic [LN*DW-1:0] av, input logic [LN*DW-1:0] bv, input logic r);
        exp_t e;
        for (int k = 0; k < LN; k++) begin
            longint p, q;
            p = longint'($signed(av[k*DW +: DW])) * longint'($signed(bv[k*DW +: DW]));
            if (r) p = p + SCALE / 2;
            q = (p >= 0) ? p / SCALE : -((-p + SCALE - 1) / SCALE);
            e.ovf[k] = (q > QMAX) || (q < QMIN);
            if (q > QMAX) q = QMAX;
            if (q < QMIN) q = QMIN;
            e.res[k*OW +: OW] = OW'(q);
        end
        return e;
    endfunction

    function automatic logic [LN*DW-1:0] rnd_vec();
        logic [LN*DW-1:0] v;
        for (int k = 0; k < LN; k++)
            v[k*DW +: DW] = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 1023)) - DW'(512);
        return v;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset && bus.out_valid && !bus.out_ready) begin
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            if (stalled_prev) begin
                check("stall_result_stable", bus.result, prev_res);
                check("stall_overflow_stable", 64'(bus.overflow), 64'(prev_ovf));
            end
            stalled_prev = 1'b1;
            prev_res = bus.result;
            prev_ovf = bus.overflow;
        end else begin
            stalled_prev = 1'b0;
        end
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_beat: got result %h expected no beat", bus.result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", bus.result, e.res);
                check("overflow", 64'(bus.overflow), 64'(e.ovf));
                if (|e.ovf) exp_ovf_cnt++;
                hs_stamp.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [LN*DW-1:0] av, input logic [LN*DW-1:0] bv, input logic r,
                        input logic [LN*OW-1:0] er, input logic [LN-1:0] eo);
        int g = 0;
        bus.in_valid = 1'b1;
        bus.a = av;
        bus.b = bv;
        bus.round_en = r;
        @(negedge clk);
        while (!bus.in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!bus.in_ready) begin
            vectors++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready 0 expected 1 within 200 cycles");
        end else begin
            exp_q.push_back({er, eo});
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [LN*DW-1:0] av, bv;
        logic r;
        exp_t e;
        av = rnd_vec();
        bv = rnd_vec();
        r = 1'($urandom_range(0, 1));
        e = model(av, bv, r);
        send(av, bv, r, e.res, e.ovf);
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL drain_timeout: got %0d beats outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500us");
        $fatal(1);
    end

    initial begin
        bit drv_done;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.round_en = 1'b0;
        bus.out_ready = 1'b1;
`ifdef FXP_MUL_OVF_COUNT_EN
        stat_clr = 1'b0;
`endif
        // lane order in literals is {lane3, lane2, lane1, lane0}
        tbl[0] = '{64'h0000_0000_0000_0180, 64'h0000_0000_0000_0200, 1'b0, 64'h0000_0000_0000_0300, 4'b0000};
        tbl[1] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0080, 1'b1, 64'h0000_0000_0000_0001, 4'b0000};
        tbl[2] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0080, 1'b0, 64'h0000_0000_0000_0000, 4'b0000};
        tbl[3] = '{64'h0000_0000_0000_FF80, 64'h0000_0000_0000_0001, 1'b0, 64'h0000_0000_0000_FFFF, 4'b0000};
        tbl[4] = '{64'h0000_0000_0000_FF80, 64'h0000_0000_0000_0001, 1'b1, 64'h0000_0000_0000_0000, 4'b0000};
        tbl[5] = '{64'h0100_8000_8000_7FFF, 64'h0100_8000_7FFF_7FFF, 1'b0, 64'h0100_7FFF_8000_7FFF, 4'b0111};
        tbl[6] = '{64'h7FFF_00B5_FFFD_0003, 64'h0100_00B5_0080_0080, 1'b1, 64'h7FFF_0080_FFFF_0002, 4'b0000};
        tbl[7] = '{64'h0000_0000_8000_7F80, 64'h0000_0000_0100_0101, 1'b1, 64'h0000_0000_8000_7FFF, 4'b0001};
        tbl[8] = '{64'h0000_0000_8000_7F80, 64'h0000_0000_0100_0101, 1'b0, 64'h0000_0000_8000_7FFF, 4'b0000};

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_result", bus.result, 64'd0);
        check("reset_overflow", 64'(bus.overflow), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef FXP_MUL_OVF_COUNT_EN
        check("reset_ovf_count", 64'(ovf_count), 64'd0);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;

        // basic multiply with latency probe
        send(tbl[0].a, tbl[0].b, tbl[0].r, tbl[0].res, tbl[0].ovf);
        @(negedge clk);
        check("latency_1cyc_out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("latency_2cyc_out_valid", 64'(bus.out_valid), 64'd1);
        wait_drain();

        for (int i = 0; i < 9; i++) send(tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].res, tbl[i].ovf);
        wait_drain();
`ifdef FXP_MUL_OVF_COUNT_EN
        check("ovf_count_table", 64'(ovf_count), 64'(exp_ovf_cnt));
`endif

        // backpressure: 10 beats, 5-cycle stall once the output is flowing
        hs_stamp.delete();
        fork
            for (int i = 0; i < 10; i++) send_rand();
            begin
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_beat_count", 64'(hs_stamp.size()), 64'd10);
        if (hs_stamp.size() == 10)
            check("bp_output_span", 64'(hs_stamp[9] - hs_stamp[0]), 64'd14);

        // randomized traffic with random idles and random backpressure
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send_rand();
                end
                drv_done = 1'b1;
            end
            while (!drv_done) begin
                @(posedge clk);
                #1 bus.out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        bus.out_ready = 1'b1;
        wait_drain();

        // reset with two beats in flight
        send(64'h0100_0100_0100_0100, 64'h0200_0200_0200_0200, 1'b0, 64'h0200_0200_0200_0200, 4'b0000);
        send(64'h0300_0300_0300_0300, 64'h0100_0100_0100_0100, 1'b0, 64'h0300_0300_0300_0300, 4'b0000);
        reset = 1'b1;
        #1;
        check("async_reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_reset_result", bus.result, 64'd0);
        check("async_reset_overflow", 64'(bus.overflow), 64'd0);
        exp_q.delete();
        exp_ovf_cnt = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
`ifdef FXP_MUL_OVF_COUNT_EN
        check("post_reset_ovf_count", 64'(ovf_count), 64'd0);
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_reset_no_stale", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        send(tbl[5].a, tbl[5].b, tbl[5].r, tbl[5].res, tbl[5].ovf);
        wait_drain();
`ifdef FXP_MUL_OVF_COUNT_EN
        check("ovf_count_after_sat", 64'(ovf_count), 64'd1);
        stat_clr = 1'b1;
        @(posedge clk);
        #1 stat_clr = 1'b0;
        check("ovf_count_cleared", 64'(ovf_count), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
